// File: rtl/fetch_control_unit.sv
// Fetch sequencing controller: arbitrates EX redirects, ID load-use stalls and imem waits
// into PC / IF-ID / ID-EX control. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module fetch_control_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_branch_taken_i,
  input  logic [DATA_WIDTH-1:0] EX_branch_target_i,
  input  logic                  ID_load_use_hazard_i,
  input  logic                  IF_imem_ready_i,
  output logic                  IF_pc_write_en_o,
  output logic                  IF_PCSrc_o,
  output logic [DATA_WIDTH-1:0] IF_branch_target_addr_o,
  output logic                  IFID_write_en_o,
  output logic                  IFID_flush_o,
  output logic                  IDEX_flush_o,
  output logic [1:0]            ctrl_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  perf_redirect_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  state_t                state, next_state;
  logic [BW-1:0]         boot_cnt;
  logic [DATA_WIDTH-1:0] redirect_q;
  logic                  latch_redirect;

  // Decision logic: outputs follow the current state and this cycle's events.
  always_comb begin
    next_state              = state;
    latch_redirect          = 1'b0;
    IF_pc_write_en_o        = 1'b0;
    IF_PCSrc_o              = 1'b0;
    IF_branch_target_addr_o = '0;
    IFID_write_en_o         = 1'b0;
    IFID_flush_o            = 1'b1;
    IDEX_flush_o            = 1'b1;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == BOOT_LAST) next_state = ST_RUN;
      end
      ST_REDIRECT: begin
        // Wrong path already squashed on entry; only the memory matters here.
        IF_PCSrc_o              = 1'b1;
        IF_branch_target_addr_o = redirect_q;
        IDEX_flush_o            = 1'b0;
        IF_pc_write_en_o        = IF_imem_ready_i;
        if (IF_imem_ready_i) next_state = ST_RUN;
      end
      ST_RUN, ST_WAIT_MEM: begin
        IF_branch_target_addr_o = EX_branch_target_i;
        if (EX_branch_taken_i && IF_imem_ready_i) begin
          IF_pc_write_en_o = 1'b1;
          IF_PCSrc_o       = 1'b1;
          next_state       = ST_RUN;
        end else if (EX_branch_taken_i) begin
          latch_redirect = 1'b1;
          next_state     = ST_REDIRECT;
        end else if (ID_load_use_hazard_i) begin
          IFID_flush_o = 1'b0;
        end else if (!IF_imem_ready_i) begin
          IDEX_flush_o = 1'b0;
          next_state   = ST_WAIT_MEM;
        end else begin
          IF_pc_write_en_o = 1'b1;
          IFID_write_en_o  = 1'b1;
          IFID_flush_o     = 1'b0;
          IDEX_flush_o     = 1'b0;
          next_state       = ST_RUN;
        end
      end
      default: next_state = ST_BOOT;
    endcase
  end

  assign ctrl_state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      boot_cnt   <= '0;
      redirect_q <= '0;
    end else begin
      state <= next_state;
      if (state == ST_BOOT) boot_cnt <= boot_cnt + BW'(1);
      if (latch_redirect) redirect_q <= EX_branch_target_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_inc, redirect_inc;
  assign stall_inc    = (state != ST_BOOT) && !IF_pc_write_en_o;
  assign redirect_inc = ((state == ST_RUN) || (state == ST_WAIT_MEM)) && EX_branch_taken_i;

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o    <= '0;
      perf_redirect_cnt_o <= '0;
    end else begin
      if (stall_inc && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + CNT_WIDTH'(1);
      if (redirect_inc && (perf_redirect_cnt_o != '1))
        perf_redirect_cnt_o <= perf_redirect_cnt_o + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit: behavioural model checked every cycle plus
// hand-computed literal checks along the test sequence.
module tb_fetch_control_unit;
  localparam int DW = 32;
  localparam int BC = 2;
  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          taken = 1'b0;
  logic [DW-1:0] tgt = '0;
  logic          haz = 1'b0;
  logic          rdy = 1'b1;

  logic          pc_we, pc_src, ifid_we, ifid_fl, idex_fl;
  logic [DW-1:0] tgt_out;
  logic [1:0]    st;
`ifdef FETCH_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, redir_cnt;
`endif

  fetch_control_unit #(.DATA_WIDTH(DW), .BOOT_CYCLES(BC), .CNT_WIDTH(CW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .EX_branch_taken_i       (taken),
    .EX_branch_target_i      (tgt),
    .ID_load_use_hazard_i    (haz),
    .IF_imem_ready_i         (rdy),
    .IF_pc_write_en_o        (pc_we),
    .IF_PCSrc_o              (pc_src),
    .IF_branch_target_addr_o (tgt_out),
    .IFID_write_en_o         (ifid_we),
    .IFID_flush_o            (ifid_fl),
    .IDEX_flush_o            (idex_fl),
    .ctrl_state_o            (st)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt_o        (stall_cnt),
    .perf_redirect_cnt_o     (redir_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "boot edges remaining", "a redirect is owed" and "last cycle waited on memory".
  int            m_boot_left = BC;
  bit            m_pending   = 1'b0;
  logic [DW-1:0] m_ptgt      = '0;
  bit            m_waited    = 1'b0;
  logic [CW-1:0] m_stall     = '0;
  logic [CW-1:0] m_redir     = '0;

  typedef struct packed {
    logic          pc_we, pc_src, ifid_we, ifid_fl, idex_fl;
    logic [DW-1:0] tgt;
    logic [1:0]    st;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e = '{pc_we:0, pc_src:0, ifid_we:0, ifid_fl:1, idex_fl:1, tgt:'0, st:2'd0};
    if (!rst_n || m_boot_left > 0) return e;
    if (m_pending) begin
      e.pc_we = rdy; e.pc_src = 1; e.tgt = m_ptgt; e.idex_fl = 0; e.st = 2'd3;
      return e;
    end
    e.st  = m_waited ? 2'd2 : 2'd1;
    e.tgt = tgt;
    if (taken && rdy)  begin e.pc_we = 1; e.pc_src = 1; end
    else if (taken)    begin end
    else if (haz)      e.ifid_fl = 0;
    else if (!rdy)     e.idex_fl = 0;
    else begin e.pc_we = 1; e.ifid_we = 1; e.ifid_fl = 0; e.idex_fl = 0; end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_boot_left <= BC; m_pending <= 0; m_ptgt <= '0; m_waited <= 0;
      m_stall <= '0; m_redir <= '0;
    end else if (m_boot_left > 0) begin
      m_boot_left <= m_boot_left - 1;
    end else begin
      e = model_out();
      if (!e.pc_we && m_stall != '1) m_stall <= m_stall + 1;
      if (m_pending) begin
        if (rdy) begin m_pending <= 0; m_waited <= 0; end
      end else begin
        if (taken && m_redir != '1) m_redir <= m_redir + 1;
        if (taken && !rdy) begin m_pending <= 1; m_ptgt <= tgt; end
        else if (taken) m_waited <= 0;
        else if (!haz) m_waited <= !rdy;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check("m_pc_we",   {31'd0, pc_we},   {31'd0, e.pc_we});
    check("m_pc_src",  {31'd0, pc_src},  {31'd0, e.pc_src});
    check("m_ifid_we", {31'd0, ifid_we}, {31'd0, e.ifid_we});
    check("m_ifid_fl", {31'd0, ifid_fl}, {31'd0, e.ifid_fl});
    check("m_idex_fl", {31'd0, idex_fl}, {31'd0, e.idex_fl});
    check("m_target",  tgt_out,          e.tgt);
    check("m_state",   {30'd0, st},      {30'd0, e.st});
`ifdef FETCH_PERF_CNT_EN
    check("m_stall_cnt", stall_cnt, m_stall);
    check("m_redir_cnt", redir_cnt, m_redir);
`endif
  end

  // ---------------- driver ----------------
  task automatic drive(input logic t, input logic [DW-1:0] a, input logic h, input logic r);
    @(posedge clk);
    #1;
    taken = t; tgt = a; haz = h; rdy = r;
    @(negedge clk);
  endtask

  task automatic check_boot_outputs(input string tag);
    check({tag, "_state"},   {30'd0, st},      32'd0);
    check({tag, "_pc_we"},   {31'd0, pc_we},   32'd0);
    check({tag, "_pc_src"},  {31'd0, pc_src},  32'd0);
    check({tag, "_tgt"},     tgt_out,          32'd0);
    check({tag, "_ifid_we"}, {31'd0, ifid_we}, 32'd0);
    check({tag, "_ifid_fl"}, {31'd0, ifid_fl}, 32'd1);
    check({tag, "_idex_fl"}, {31'd0, idex_fl}, 32'd1);
  endtask

  initial begin
    // Reset release: two BOOT cycles then RUN.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_boot_outputs("boot1");
    drive(0, '0, 0, 1);
    check_boot_outputs("boot2");
    drive(0, '0, 0, 1);
    check("run_state",   {30'd0, st},      32'd1);
    check("run_pc_we",   {31'd0, pc_we},   32'd1);
    check("run_pc_src",  {31'd0, pc_src},  32'd0);
    check("run_ifid_we", {31'd0, ifid_we}, 32'd1);

    // Branch in RUN, memory ready.
    drive(1, 32'h100, 0, 1);
    check("br_pc_we",  {31'd0, pc_we},  32'd1);
    check("br_pc_src", {31'd0, pc_src}, 32'd1);
    check("br_tgt",    tgt_out,         32'h100);
    check("br_flush",  {30'd0, ifid_fl, idex_fl}, 32'd3);
    drive(0, '0, 0, 1);
    check("br_next_src",   {31'd0, pc_src}, 32'd0);
    check("br_next_flush", {30'd0, ifid_fl, idex_fl}, 32'd0);

    // Load-use stall, one cycle.
    drive(0, '0, 1, 1);
    check("lu_ctrl", {28'd0, pc_we, ifid_we, idex_fl, ifid_fl}, 32'b0010);
    drive(0, '0, 0, 1);
    check("lu_next_pc_we", {31'd0, pc_we}, 32'd1);

    // Memory wait without a branch, then a load-use while waiting.
    drive(0, '0, 0, 0);
    check("wm_ctrl", {28'd0, pc_we, ifid_we, ifid_fl, idex_fl}, 32'b0010);
    drive(0, '0, 1, 0);
    check("wm_state", {30'd0, st}, 32'd2);
    drive(0, '0, 0, 1);
    check("wm_state_hold", {30'd0, st}, 32'd2);
    drive(0, '0, 0, 1);
    check("wm_back_run", {30'd0, st}, 32'd1);

    // Branch during wait: deferred redirect to 0x200.
    drive(1, 32'h200, 0, 0);
    check("dr_pc_we", {31'd0, pc_we}, 32'd0);
    check("dr_flush", {30'd0, ifid_fl, idex_fl}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 32'h500, i == 2, 0);
      check("dr_wait_state", {30'd0, st},    32'd3);
      check("dr_wait_tgt",   tgt_out,        32'h200);
      check("dr_wait_pc_we", {31'd0, pc_we}, 32'd0);
    end
    drive(0, 32'h500, 0, 1);
    check("dr_go_pc_we",  {31'd0, pc_we},  32'd1);
    check("dr_go_pc_src", {31'd0, pc_src}, 32'd1);
    check("dr_go_tgt",    tgt_out,         32'h200);
    drive(0, '0, 0, 1);
    check("dr_after_state", {30'd0, st}, 32'd1);

    // Branch and load-use together: branch wins.
    drive(1, 32'h300, 1, 1);
    check("bl_ctrl", {27'd0, pc_we, pc_src, ifid_we, ifid_fl, idex_fl}, 32'b11011);
    check("bl_tgt",  tgt_out, 32'h300);

    // Async reset while in REDIRECT.
    drive(1, 32'h400, 0, 0);
    drive(0, '0, 0, 0);
    check("ar_pre_state", {30'd0, st}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_boot_outputs("ar");
`ifdef FETCH_PERF_CNT_EN
    check("ar_stall_cnt", stall_cnt, 32'd0);
    check("ar_redir_cnt", redir_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 1);
    check("ar_rerun_state", {30'd0, st}, 32'd1);
    drive(0, '0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
